axi_lite_mem_slave: RTL and testbench
=====================================

Name: axi_lite_mem_slave

Overview:
AXI4-Lite slave word memory that sits directly downstream of the bus interconnect and terminates one of its master ports (m1 or m2). It accepts write address/data and read address transactions, stores DATA_WIDTH-bit words in an internal register array with byte strobes, and returns write/read responses. It decodes the low address bits only; region selection is already done upstream by the interconnect.

Parameters:
DATA_WIDTH, 32, data bus width in bits (multiple of 8)
ADDR_WIDTH, 8, byte address width
RESP_WIDTH, 3, response field width, matching the interconnect
DEPTH, 16, number of DATA_WIDTH words stored (power of 2, DEPTH*4 <= 2**ADDR_WIDTH)

Ports:
s_axi_aclk  in  1  single clock; all logic on rising edge
s_axi_aresetn  in  1  reset, asynchronous assert, active-low
s_axi_awaddr  in  ADDR_WIDTH  write byte address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address accepted
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8+1  byte strobes; bit i enables byte i; MSB ignored (interconnect port width)
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data accepted
s_axi_bresp  out  RESP_WIDTH  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response accepted
s_axi_araddr  in  ADDR_WIDTH  read byte address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address accepted
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  RESP_WIDTH  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data accepted

Behaviour:
- Reset (aresetn=0, async): all readies, bvalid, rvalid = 0; bresp, rresp, rdata = 0; all memory words = 0; both FSMs to IDLE; init flag cleared. Init flag sets on first clock edge after release; readies stay 0 until it is set.
- Word index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored. Index >= DEPTH -> out of range. OKAY = 0, SLVERR = 2 (zero-extended to RESP_WIDTH).
- Write FSM states: W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP. awready = init & (W_IDLE|W_WAIT_ADDR); wready = init & (W_IDLE|W_WAIT_DATA); both decoded from registered state only, with no combinational path from valid to ready.
- W_IDLE: aw & w handshake on the same edge -> commit, go W_RESP; aw only -> latch addr, go W_WAIT_DATA; w only -> latch data and strobes, go W_WAIT_ADDR.
- W_WAIT_DATA / W_WAIT_ADDR: when the missing handshake completes -> commit, go W_RESP.
- Commit: if in range, write byte i of the word when wstrb[i]=1; bytes with strobe 0 keep their value. Out of range: no memory change. bvalid=1 and bresp set on the edge after commit (latency 1 cycle from the last handshake).
- W_RESP: hold bvalid and bresp stable until bready=1 on an edge -> bvalid=0, W_IDLE. Next AW/W is not accepted in the same cycle as the B handshake.
- Read FSM states: R_IDLE, R_RESP. arready = init & R_IDLE. On AR handshake, register rdata = mem[index] (0 if out of range) and rresp = OKAY/SLVERR, rvalid=1 on the next edge, go R_RESP. Latency is 1 cycle.
- R_RESP: rdata, rresp and rvalid are held stable until rready=1 on an edge -> rvalid=0, R_IDLE.
- Read and write channels are independent and may be active concurrently. If a read capture and a write commit hit the same word on the same edge, the read returns the pre-write value.
- Any valid held during reset is ignored. Reset mid-transaction drops it with no response. Partially latched AW/W is discarded.
- Only one outstanding transaction per channel.

Test Plan:
- Reset release, awvalid=wvalid=1, awaddr=16, wdata=37, wstrb=0xF, bready=0 -> awready/wready high on the first edge after init. bvalid=1, bresp=0 the next cycle and held for 3 cycles until bready=1. Then read araddr=16 returns rdata=37, rresp=0 after 1 cycle.
- Write word 0 with 0xAABBCCDD and wstrb 0xF, then 0x11223344 with wstrb 0x5 -> read addr 0 returns 0xAA22CC44.
- AW first (addr 4) then W 3 cycles later (0x55) -> FSM visits W_WAIT_DATA and wready stays high, bvalid is asserted 1 cycle after the W handshake. Repeat with W first then AW -> same result, read addr 4 returns 0x55.
- awaddr=64 (index 16, DEPTH=16) with wdata 0xDEAD -> bresp=2 and memory unchanged. araddr=64 -> rdata=0, rresp=2.
- Same-edge read of addr 8 while writing 0x99 to addr 8 (old value 0x7) -> rdata=0x7. A subsequent read returns 0x99.
- Assert aresetn=0 while in W_RESP with bvalid=1 -> bvalid=0 immediately (async) and memory reads 0 after reset.

Source files
------------

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave word memory. Terminates one interconnect master port and
// decodes only the low address bits into a DEPTH-word register array with
// byte strobes. Write and read channels run as independent FSMs with a
// single outstanding transaction each and one-cycle response latency.
module axi_lite_mem_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int DEPTH      = 16
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [RESP_WIDTH-1:0]   s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int IDXW = ADDR_WIDTH - 2;
  localparam int MAW  = $clog2(DEPTH);

  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

  typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_RESP} rstate_e;

  // Word index is addr[ADDR_WIDTH-1:2]; anything at or above DEPTH is a miss.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [IDXW-1:0] idx;
    idx = a[ADDR_WIDTH-1:2];
    return ((idx >> MAW) == '0);
  endfunction

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic                             init_q;

  wstate_e                wstate_q, wstate_d;
  logic [ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [NB-1:0]          wstrb_q, wstrb_d;
  logic                   bvalid_q, bvalid_d;
  logic [RESP_WIDTH-1:0]  bresp_q, bresp_d;

  rstate_e                rstate_q, rstate_d;
  logic                   rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [RESP_WIDTH-1:0]  rresp_q, rresp_d;

  logic                   aw_hs, w_hs, ar_hs;
  logic                   commit;
  logic [ADDR_WIDTH-1:0]  cm_addr;
  logic [DATA_WIDTH-1:0]  cm_data;
  logic [NB-1:0]          cm_strb;
  logic                   cm_in;
  logic                   rd_in;

  // Address bits 1:0 and the extra strobe bit carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s_axi_wstrb[NB], s_axi_awaddr[1:0], s_axi_araddr[1:0], awaddr_q[1:0]};

  // Readies come from registered state only, never from the valids.
  assign s_axi_awready = init_q & ((wstate_q == W_IDLE) | (wstate_q == W_WAIT_ADDR));
  assign s_axi_wready  = init_q & ((wstate_q == W_IDLE) | (wstate_q == W_WAIT_DATA));
  assign s_axi_arready = init_q & (rstate_q == R_IDLE);
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid  & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  // Commit operands: take whichever half was latched earlier, else the live bus.
  assign cm_addr = (wstate_q == W_WAIT_DATA) ? awaddr_q : s_axi_awaddr;
  assign cm_data = (wstate_q == W_WAIT_ADDR) ? wdata_q  : s_axi_wdata;
  assign cm_strb = (wstate_q == W_WAIT_ADDR) ? wstrb_q  : s_axi_wstrb[NB-1:0];
  assign cm_in   = in_range(cm_addr);
  assign rd_in   = in_range(s_axi_araddr);

  // Init flag: holds readies low for the first edge after reset release.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) init_q <= 1'b0;
    else                init_q <= 1'b1;
  end

  // Write FSM next state, address/data latching and response generation.
  always_comb begin
    wstate_d = wstate_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    commit   = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit   = 1'b1;
          wstate_d = W_RESP;
        end else if (aw_hs) begin
          awaddr_d = s_axi_awaddr;
          wstate_d = W_WAIT_DATA;
        end else if (w_hs) begin
          wdata_d  = s_axi_wdata;
          wstrb_d  = s_axi_wstrb[NB-1:0];
          wstate_d = W_WAIT_ADDR;
        end
      end
      W_WAIT_DATA: begin
        if (w_hs) begin
          commit   = 1'b1;
          wstate_d = W_RESP;
        end
      end
      W_WAIT_ADDR: begin
        if (aw_hs) begin
          commit   = 1'b1;
          wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          bvalid_d = 1'b0;
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = cm_in ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Write FSM registers.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wstate_q <= W_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
    end else begin
      wstate_q <= wstate_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
    end
  end

  // Memory array: byte-strobed write on commit; out-of-range commits are dropped.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      mem_q <= '0;
    end else if (commit && cm_in) begin
      for (int b = 0; b < NB; b++) begin
        if (cm_strb[b]) mem_q[cm_addr[MAW+1:2]][b*8 +: 8] <= cm_data[b*8 +: 8];
      end
    end
  end

  // Read FSM next state. mem_q is sampled before this edge's write lands,
  // so a same-edge read of the written word returns the old value.
  always_comb begin
    rstate_d = rstate_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          rstate_d = R_RESP;
          rvalid_d = 1'b1;
          rdata_d  = rd_in ? mem_q[s_axi_araddr[MAW+1:2]] : '0;
          rresp_d  = rd_in ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_RESP: begin
        if (s_axi_rready) begin
          rvalid_d = 1'b0;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Read FSM registers.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rstate_q <= R_IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= '0;
    end else begin
      rstate_q <= rstate_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Directed bench for axi_lite_mem_slave (DATA 32, ADDR 8, RESP 3, DEPTH 16).
module tb_axi_lite_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [31:0] wdata, rdata;
  logic [4:0]  wstrb;
  logic [2:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_d;
  logic [2:0]  rd_r, wr_r;

  always #5 clk = ~clk;

  axi_lite_mem_slave dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                          output logic [2:0] resp);
    logic ah, wh;
    bit   done;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
      ah = awvalid & awready;
      wh = wvalid & wready;
      tick();
      if (ah) awvalid = 1'b0;
      if (wh) wvalid = 1'b0;
    end
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bvalid) done = 1;
      else tick();
    end
    chk("write_handshake_timeout", {31'd0, done && !awvalid && !wvalid}, 32'd1);
    awvalid = 1'b0; wvalid = 1'b0;
    resp = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [2:0] resp);
    logic hs;
    bit   done;
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 20 && arvalid; i++) begin
      hs = arready;
      tick();
      if (hs) arvalid = 1'b0;
    end
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (rvalid) done = 1;
      else tick();
    end
    chk("read_handshake_timeout", {31'd0, done && !arvalid}, 32'd1);
    arvalid = 1'b0;
    d = rdata; resp = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    // Reset with write valids already asserted; they must be ignored.
    rst_n = 1'b0;
    awaddr = 8'd16; wdata = 32'd37; wstrb = 5'hF; awvalid = 1'b1; wvalid = 1'b1;
    bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    tick(); tick();
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready", {31'd0, wready}, 32'd0);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    chk("pre_init_awready", {31'd0, awready}, 32'd0);
    tick();
    chk("init_awready", {31'd0, awready}, 32'd1);
    chk("init_wready", {31'd0, wready}, 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("b_lat1_bvalid", {31'd0, bvalid}, 32'd1);
    chk("b_lat1_bresp", {29'd0, bresp}, 32'd0);
    chk("wresp_awready", {31'd0, awready}, 32'd0);
    tick(); tick();
    chk("b_hold_bvalid", {31'd0, bvalid}, 32'd1);
    chk("b_hold_bresp", {29'd0, bresp}, 32'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("b_done_bvalid", {31'd0, bvalid}, 32'd0);
    // Read back with exact latency.
    araddr = 8'd16; arvalid = 1'b1;
    chk("arready_idle", {31'd0, arready}, 32'd1);
    tick();
    arvalid = 1'b0;
    chk("r_lat1_rvalid", {31'd0, rvalid}, 32'd1);
    chk("r_lat1_rdata", rdata, 32'd37);
    chk("r_lat1_rresp", {29'd0, rresp}, 32'd0);
    chk("rresp_arready", {31'd0, arready}, 32'd0);
    tick();
    chk("r_hold_rdata", rdata, 32'd37);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("r_done_rvalid", {31'd0, rvalid}, 32'd0);
    // Low address bits ignored: 0x13 maps to word 4.
    do_read(8'h13, rd_d, rd_r);
    chk("lowbits_rdata", rd_d, 32'd37);

    // Byte strobes.
    do_write(8'h00, 32'hAABBCCDD, 5'h0F, wr_r);
    chk("strb_full_bresp", {29'd0, wr_r}, 32'd0);
    do_write(8'h00, 32'h11223344, 5'h15, wr_r);
    do_read(8'h00, rd_d, rd_r);
    chk("strb_partial_rdata", rd_d, 32'hAA22CC44);

    // AW first, W three cycles later.
    awaddr = 8'd4; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("wait_data_awready", {31'd0, awready}, 32'd0);
    chk("wait_data_wready", {31'd0, wready}, 32'd1);
    tick(); tick();
    chk("wait_data_wready_held", {31'd0, wready}, 32'd1);
    chk("wait_data_no_bvalid", {31'd0, bvalid}, 32'd0);
    wdata = 32'h55; wstrb = 5'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("aw_first_bvalid", {31'd0, bvalid}, 32'd1);
    bready = 1'b1; tick(); bready = 1'b0;
    do_read(8'd4, rd_d, rd_r);
    chk("aw_first_rdata", rd_d, 32'h55);

    // W first, then AW.
    wdata = 32'h5500AA; wstrb = 5'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("wait_addr_wready", {31'd0, wready}, 32'd0);
    chk("wait_addr_awready", {31'd0, awready}, 32'd1);
    tick(); tick();
    wdata = 32'hFFFFFFFF;
    awaddr = 8'd20; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("w_first_bvalid", {31'd0, bvalid}, 32'd1);
    chk("w_first_bresp", {29'd0, bresp}, 32'd0);
    bready = 1'b1; tick(); bready = 1'b0;
    do_read(8'd20, rd_d, rd_r);
    chk("w_first_rdata", rd_d, 32'h5500AA);
    do_read(8'd4, rd_d, rd_r);
    chk("w_first_other_word", rd_d, 32'h55);

    // Out of range: index 16 must not alias onto word 0.
    do_write(8'd64, 32'hDEAD, 5'hF, wr_r);
    chk("oor_bresp", {29'd0, wr_r}, 32'd2);
    do_read(8'd64, rd_d, rd_r);
    chk("oor_rdata", rd_d, 32'd0);
    chk("oor_rresp", {29'd0, rd_r}, 32'd2);
    do_read(8'd0, rd_d, rd_r);
    chk("oor_word0_intact", rd_d, 32'hAA22CC44);
    do_read(8'hFC, rd_d, rd_r);
    chk("oor_top_rresp", {29'd0, rd_r}, 32'd2);
    do_read(8'd60, rd_d, rd_r);
    chk("last_word_rresp", {29'd0, rd_r}, 32'd0);

    // Same-edge read and write of one word returns the old value.
    do_write(8'd8, 32'h7, 5'hF, wr_r);
    araddr = 8'd8; arvalid = 1'b1;
    awaddr = 8'd8; wdata = 32'h99; wstrb = 5'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("same_edge_rvalid", {31'd0, rvalid}, 32'd1);
    chk("same_edge_bvalid", {31'd0, bvalid}, 32'd1);
    chk("same_edge_rdata", rdata, 32'h7);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    do_read(8'd8, rd_d, rd_r);
    chk("after_same_edge_rdata", rd_d, 32'h99);

    // Async reset while a write response is pending.
    awaddr = 8'd12; wdata = 32'h1234; wstrb = 5'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    chk("pre_reset_bvalid", {31'd0, bvalid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_bvalid", {31'd0, bvalid}, 32'd0);
    chk("async_reset_awready", {31'd0, awready}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_read(8'd0, rd_d, rd_r);
    chk("post_reset_word0", rd_d, 32'd0);
    do_read(8'd12, rd_d, rd_r);
    chk("post_reset_word3", rd_d, 32'd0);
    chk("post_reset_bvalid", {31'd0, bvalid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
